// File: rtl/reg_bus_master.sv
// Byte-stream command parser that acts as initiator on the shared register bus.
// Optional inter-byte timeout abort: define REG_BUS_MASTER_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module reg_bus_master #(
   parameter int ADDR_WIDTH     = `ADDR_WIDTH,
   parameter int DATA_WIDTH     = `DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_bus_wr,
   output logic [ADDR_WIDTH-1:0] o_bus_addr,
   output logic [DATA_WIDTH-1:0] o_bus_wdata,
   input  logic [DATA_WIDTH-1:0] i_bus_rdata,
   output logic                  o_busy
);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h45;

   typedef enum logic [3:0] {
      IDLE, GET_AH, GET_AL, GET_CNT, WR_DATA, WR_STROBE,
      RD_ADDR, RD_WAIT, RD_SEND, ACK_SEND, ERR_SEND
   } state_t;

   state_t                state_q, state_d;
   logic                  is_wr_q, is_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  rx_accept;
   logic                  tx_done;
   logic                  in_parse;
   logic                  timeout_hit;

   assign o_rx_ready  = (state_q == IDLE) || in_parse;
   assign in_parse    = (state_q == GET_AH) || (state_q == GET_AL) ||
                        (state_q == GET_CNT) || (state_q == WR_DATA);
   assign o_tx_valid  = (state_q == RD_SEND) || (state_q == ACK_SEND) ||
                        (state_q == ERR_SEND);
   assign o_bus_wr    = (state_q == WR_STROBE);
   assign o_busy      = (state_q != IDLE);
   assign o_bus_addr  = bus_addr_q;
   assign o_bus_wdata = wdata_q;
   assign o_tx_data   = tx_data_q;
   assign rx_accept   = i_rx_valid && o_rx_ready;
   assign tx_done     = o_tx_valid && i_tx_ready;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q;

   // Counts idle cycles between accepted bytes while a frame is being parsed.
   always_ff @(posedge i_clk) begin
      if (i_rst || rx_accept || !in_parse) to_q <= '0;
      else                                 to_q <= to_q + TO_W'(1);
   end

   assign timeout_hit = in_parse && !rx_accept && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      bus_addr_d = bus_addr_q;
      wdata_d    = wdata_q;
      tx_data_d  = tx_data_q;

      case (state_q)
         IDLE: if (rx_accept) begin
            if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
               is_wr_d = (i_rx_data == CMD_WRITE);
               state_d = GET_AH;
            end else begin
               tx_data_d = RSP_ERR;
               state_d   = ERR_SEND;
            end
         end
         GET_AH: if (rx_accept) begin
            // High byte lands above bit 7; bits beyond ADDR_WIDTH fall away.
            addr_d  = ADDR_WIDTH'({i_rx_data, 8'h00});
            state_d = GET_AL;
         end
         GET_AL: if (rx_accept) begin
            addr_d  = addr_q | ADDR_WIDTH'(i_rx_data);
            state_d = GET_CNT;
         end
         GET_CNT: if (rx_accept) begin
            cnt_d = i_rx_data;
            if (i_rx_data == 8'd0) begin
               tx_data_d = RSP_ACK;
               state_d   = ACK_SEND;
            end else if (is_wr_q) begin
               state_d = WR_DATA;
            end else begin
               bus_addr_d = addr_q;
               state_d    = RD_ADDR;
            end
         end
         WR_DATA: if (rx_accept) begin
            bus_addr_d = addr_q;
            wdata_d    = DATA_WIDTH'(i_rx_data);
            state_d    = WR_STROBE;
         end
         WR_STROBE: begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               tx_data_d = RSP_ACK;
               state_d   = ACK_SEND;
            end else begin
               state_d = WR_DATA;
            end
         end
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: begin
            tx_data_d = 8'(i_bus_rdata);
            state_d   = RD_SEND;
         end
         RD_SEND: if (tx_done) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = IDLE;
            end else begin
               bus_addr_d = addr_q + ADDR_WIDTH'(1);
               state_d    = RD_ADDR;
            end
         end
         ACK_SEND, ERR_SEND: if (tx_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         tx_data_d = RSP_ERR;
         state_d   = ERR_SEND;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         is_wr_q    <= 1'b0;
         addr_q     <= '0;
         cnt_q      <= '0;
         bus_addr_q <= '0;
         wdata_q    <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         bus_addr_q <= bus_addr_d;
         wdata_q    <= wdata_d;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: frame-level reference model, bus memory model, random traffic.
module tb_reg_bus_master;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
   localparam int TO_CYC = 50;
`else
   localparam int TO_CYC = 1000000;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       bus_wr;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata = 8'h00;
   logic       busy;

   reg_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_bus_wr(bus_wr), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
      .i_bus_rdata(bus_rdata), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-bank model: reset loads mem[a] = a+1, one-cycle registered read.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
      end else if (bus_wr) begin
         mem[bus_addr] <= bus_wdata;
      end
      bus_rdata <= mem[bus_addr];
   end

   // Observed traffic logs, only appended here.
   logic [7:0] wr_a[$];
   logic [7:0] wr_d[$];
   int         wr_c[$];
   logic [7:0] tx_q[$];
   always @(negedge clk) begin
      if (!rst && bus_wr) begin
         wr_a.push_back(bus_addr);
         wr_d.push_back(bus_wdata);
         wr_c.push_back(cyc);
      end
      if (!rst && tx_valid && tx_ready) tx_q.push_back(tx_data);
   end

   // Sink back-pressure driver.
   logic hold_low = 1'b0;
   logic bp_mode  = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         tx_ready = !hold_low && (!bp_mode || ($urandom_range(0, 3) != 0));
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state and expectations.
   logic [7:0] ref_mem [256];
   logic [7:0] exp_wa[$];
   logic [7:0] exp_wd[$];
   logic [7:0] exp_tx[$];
   logic [7:0] frame_data[$];
   int         wr_ptr = 0;
   int         tx_ptr = 0;
   int         last_acc = 0;

   task automatic ref_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 1);
   endtask

   task automatic model_frame(input logic [7:0] cmd, input logic [7:0] al, input logic [7:0] cnt);
      logic [7:0] a;
      a = al;
      if (cmd == 8'h57) begin
         for (int i = 0; i < int'(cnt); i++) begin
            exp_wa.push_back(a);
            exp_wd.push_back(frame_data[i]);
            ref_mem[a] = frame_data[i];
            a = a + 8'd1;
         end
         exp_tx.push_back(8'h4B);
      end else if (cmd == 8'h52) begin
         if (cnt == 8'd0) exp_tx.push_back(8'h4B);
         for (int i = 0; i < int'(cnt); i++) begin
            exp_tx.push_back(ref_mem[a]);
            a = a + 8'd1;
         end
      end else begin
         exp_tx.push_back(8'h45);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      last_acc = cyc;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] ah,
                             input logic [7:0] al, input logic [7:0] cnt);
      @(posedge clk);
      #1;
      send_byte(cmd);
      if (cmd == 8'h57 || cmd == 8'h52) begin
         send_byte(ah);
         send_byte(al);
         send_byte(cnt);
         if (cmd == 8'h57)
            for (int i = 0; i < int'(cnt); i++) send_byte(frame_data[i]);
      end
   endtask

   task automatic check_logs(input string tag);
      int n;
      n = 0;
      while (tx_q.size() < exp_tx.size() && n < 3000) begin
         n++;
         @(negedge clk);
      end
      n = 0;
      while (busy && n < 3000) begin
         n++;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
      check({tag, "_wr_count"}, 32'(wr_a.size()), 32'(exp_wa.size()));
      for (int i = tx_ptr; i < exp_tx.size() && i < tx_q.size(); i++)
         check($sformatf("%s_tx[%0d]", tag, i - tx_ptr), 32'(tx_q[i]), 32'(exp_tx[i]));
      for (int i = wr_ptr; i < exp_wa.size() && i < wr_a.size(); i++) begin
         check($sformatf("%s_wr_addr[%0d]", tag, i - wr_ptr), 32'(wr_a[i]), 32'(exp_wa[i]));
         check($sformatf("%s_wr_data[%0d]", tag, i - wr_ptr), 32'(wr_d[i]), 32'(exp_wd[i]));
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
      tx_ptr = exp_tx.size();
      wr_ptr = exp_wa.size();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     32'(busy),      32'd0);
      check({tag, "_rx_ready"}, 32'(rx_ready),  32'd1);
      check({tag, "_tx_valid"}, 32'(tx_valid),  32'd0);
      check({tag, "_tx_data"},  32'(tx_data),   32'd0);
      check({tag, "_bus_wr"},   32'(bus_wr),    32'd0);
      check({tag, "_bus_addr"}, 32'(bus_addr),  32'd0);
      check({tag, "_wdata"},    32'(bus_wdata), 32'd0);
   endtask

   initial begin
      int base;
      int acc_ab;
      int n;
      int unstable;
      logic [7:0] d0, a0;
      logic [7:0] cmd, ah, al, cnt;

      ref_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Single write.
      frame_data = '{8'hAB};
      base = wr_a.size();
      model_frame(8'h57, 8'h10, 8'd1);
      send_frame(8'h57, 8'h00, 8'h10, 8'd1);
      acc_ab = last_acc;
      check_logs("single_wr");
      if (wr_c.size() > base) check("single_wr_timing", 32'(wr_c[base]), 32'(acc_ab));

      // Burst read, bank returns addr+1.
      base = wr_a.size();
      model_frame(8'h52, 8'h20, 8'd3);
      send_frame(8'h52, 8'h00, 8'h20, 8'd3);
      check_logs("burst_rd");
      check("burst_rd_no_wr", 32'(wr_a.size()), 32'(base));

      // Back-pressured burst read.
      @(posedge clk);
      #1 hold_low = 1'b1;
      model_frame(8'h52, 8'h20, 8'd3);
      send_frame(8'h52, 8'h00, 8'h20, 8'd3);
      n = 0;
      @(negedge clk);
      while (!tx_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("bp_valid", 32'(tx_valid), 32'd1);
      d0 = tx_data;
      a0 = bus_addr;
      check("bp_first_data", 32'(d0), 32'h21);
      unstable = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx_data !== d0 || bus_addr !== a0 || bus_wr || !tx_valid) unstable++;
      end
      check("bp_stable", 32'(unstable), 32'd0);
      @(posedge clk);
      #1 hold_low = 1'b0;
      check_logs("bp_rd");

      // Unknown command, then zero-count write.
      model_frame(8'h33, 8'h00, 8'd0);
      send_frame(8'h33, 8'h00, 8'h00, 8'd0);
      check_logs("bad_cmd");
      model_frame(8'h57, 8'h05, 8'd0);
      send_frame(8'h57, 8'h00, 8'h05, 8'd0);
      check_logs("wr_cnt0");
      model_frame(8'h52, 8'h05, 8'd0);
      send_frame(8'h52, 8'h00, 8'h05, 8'd0);
      check_logs("rd_cnt0");

      // Address wrap; high address byte ignored at width 8.
      frame_data = '{8'h11, 8'h22};
      model_frame(8'h57, 8'hFF, 8'd2);
      send_frame(8'h57, 8'h3C, 8'hFF, 8'd2);
      check_logs("wrap_wr");
      model_frame(8'h52, 8'hFF, 8'd2);
      send_frame(8'h52, 8'h00, 8'hFF, 8'd2);
      check_logs("wrap_rd");

      // Reset after 1 of 3 data bytes of a burst write.
      @(posedge clk);
      #1;
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h40);
      send_byte(8'd3);
      send_byte(8'h11);
      exp_wa.push_back(8'h40);
      exp_wd.push_back(8'h11);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ref_reset();
      @(negedge clk);
      check_reset_outputs("rst_mid");
      check_logs("rst_mid");

`ifdef REG_BUS_MASTER_TIMEOUT_EN
      // Stalled frame aborts after TO_CYC idle cycles.
      @(posedge clk);
      #1;
      send_byte(8'h57);
      send_byte(8'h00);
      acc_ab = last_acc;
      n = 0;
      @(negedge clk);
      while (!tx_valid && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("timeout_delay", 32'(cyc - acc_ab), 32'(TO_CYC));
      exp_tx.push_back(8'h45);
      check_logs("timeout");
`endif

      // Random frames with random sink stalls.
      bp_mode = 1'b1;
      for (int f = 0; f < 30; f++) begin
         n = $urandom_range(0, 7);
         if (n < 3)      cmd = 8'h57;
         else if (n < 6) cmd = 8'h52;
         else begin
            cmd = 8'($urandom_range(0, 255));
            while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom_range(0, 255));
         end
         ah  = 8'($urandom_range(0, 255));
         al  = 8'($urandom_range(0, 255));
         cnt = 8'($urandom_range(0, 6));
         frame_data.delete();
         for (int i = 0; i < int'(cnt); i++) frame_data.push_back(8'($urandom_range(0, 255)));
         model_frame(cmd, al, cnt);
         send_frame(cmd, ah, al, cnt);
         check_logs($sformatf("rand%0d", f));
      end
      bp_mode = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
